cpu_sequencer: RTL



---
 rtl/cpu_pkg.sv | 26 ++
 rtl/cpu_alu.sv | 22 ++
 rtl/cpu_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared ISA constants and sequencer state type for the 8-bit accumulator CPU.
package cpu_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_WRITE,
        S_WREND,
        S_HALT
    } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational accumulator ALU: ADD/AND/XOR on the operand, LDA passes it through.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = acc;
        case (opcode)
            OP_ADD:  result = acc + operand;
            OP_AND:  result = acc & operand;
            OP_XOR:  result = acc ^ operand;
            OP_LDA:  result = operand;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute controller: owns PC/IR/ACC and is sole master of the memory bus.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic              mrd,
    output logic              mwr,
    output logic [ADDR_W-1:0] mad,
    inout  wire  [DATA_W-1:0] mdat,
    output logic              halt,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc
);

    state_t            state;
    logic [DATA_W-1:0] ir;
    logic              drive;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] branch_pc;

    // ACC is stable through WRITE/WREND, so it doubles as the store data.
    assign mdat = drive ? acc : 'z;

    cpu_alu u_alu (
        .opcode  (ir[7:5]),
        .acc     (acc),
        .operand (mdat),
        .result  (alu_result)
    );

    always_comb begin
        branch_pc = ir[ADDR_W-1:0];
        if (ir[7:5] == OP_SKZ)
            branch_pc = (acc == '0) ? pc + 5'd1 : pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            acc   <= '0;
            mrd   <= 1'b0;
            mwr   <= 1'b0;
            mad   <= '0;
            drive <= 1'b0;
            halt  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                    mrd   <= 1'b1;
                    mad   <= pc;
                end
                S_FETCH: begin
                    ir    <= mdat;
                    pc    <= pc + 5'd1;
                    mrd   <= 1'b0;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (ir[7:5])
                        OP_HLT: begin
                            state <= S_HALT;
                            halt  <= 1'b1;
                        end
                        OP_SKZ, OP_JMP: begin
                            pc    <= branch_pc;
                            mad   <= branch_pc;
                            mrd   <= 1'b1;
                            state <= S_FETCH;
                        end
                        OP_STO: begin
                            mad   <= ir[ADDR_W-1:0];
                            mwr   <= 1'b1;
                            drive <= 1'b1;
                            state <= S_WRITE;
                        end
                        default: begin
                            mad   <= ir[ADDR_W-1:0];
                            mrd   <= 1'b1;
                            state <= S_READ;
                        end
                    endcase
                end
                S_READ: begin
                    acc   <= alu_result;
                    mad   <= pc;
                    state <= S_FETCH;
                end
                S_WRITE: begin
                    mwr   <= 1'b0;
                    state <= S_WREND;
                end
                S_WREND: begin
                    drive <= 1'b0;
                    mad   <= pc;
                    mrd   <= 1'b1;
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
